// File: rtl/fsqrt_newton_iter.sv
// Single-precision square root using a seed table and Newton-Raphson 1/sqrt refinement.
// Latency: done 3*ITER+3 edges after acceptance for finite positive operands, 2 edges for special operands.
// Backpressure: start is taken only while idle (or in the done cycle) with cancel low; cancel aborts in-flight work.
// Ports: clk/clrn clock and async active-low reset; d/rm operand and rounding mode; start/cancel control;
//        s result, done one-cycle valid pulse, busy in-flight flag, invalid/inexact flags, count iteration index.
module fsqrt_newton_iter #(
  parameter int ITER     = 3,
  parameter int LUT_BITS = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] d,
  input  logic [1:0]  rm,
  input  logic        start,
  input  logic        cancel,
  output logic [31:0] s,
  output logic        done,
  output logic        busy,
  output logic        invalid,
  output logic        inexact,
  output logic [2:0]  count
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ITER  = 3'd2;
  localparam logic [2:0] ST_MUL   = 3'd3;
  localparam logic [2:0] ST_ROUND = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Seed x0 ~= 1/sqrt(midpoint of table cell), 16 fractional bits. The operand a
  // lies in [1,4), so cells below index 2^(LUT_BITS-2) are never addressed.
  function automatic logic [16:0] rsqrt_seed(input int idx);
    logic [63:0] n, root, t;
    root = 64'd0;
    if (idx >= (1 << (LUT_BITS - 2))) begin
      n = (64'd1 << (31 + LUT_BITS)) / 64'(2 * idx + 1);
      for (int b = 20; b >= 0; b--) begin
        t = root | (64'd1 << b);
        if (t * t <= n) root = t;
      end
    end
    return 17'(root);
  endfunction

  logic [2:0]  r_state, r_cnt;
  logic [1:0]  r_phase, r_rm;
  logic [24:0] r_m;       // a in [1,4), 2.23 fixed point
  logic [7:0]  r_exp;     // biased result exponent
  logic        r_spec, r_sinv;
  logic [31:0] r_sres;
  logic [33:0] r_x;       // 1/sqrt(a) estimate, 2.32
  logic [35:0] r_t;       // x^2 then a*x^2, 4.32
  logic [25:0] r_q;       // sqrt(a) * 2^25, truncated
  logic [31:0] r_s;
  logic        r_inv, r_inx;

  // Operand unpack: normalise denormals, then fold an odd exponent into the significand.
  logic [4:0]  w_lz;
  logic [23:0] w_m24;
  logic [24:0] w_m25;
  logic [9:0]  w_eu, w_ev, w_eh;
  logic [7:0]  w_exp;
  logic        w_spec, w_sinv;
  logic [31:0] w_sres;

  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 23; i++)
      if (d[i]) w_lz = 5'(22 - i);
    if (d[30:23] == 8'd0) begin
      w_m24 = {1'b0, d[22:0]} << (w_lz + 5'd1);
      w_eu  = 10'(-127) - 10'(w_lz);
    end else begin
      w_m24 = {1'b1, d[22:0]};
      w_eu  = 10'({2'b00, d[30:23]}) - 10'd127;
    end
    w_m25 = w_eu[0] ? {w_m24, 1'b0} : {1'b0, w_m24};
    w_ev  = w_eu - 10'(w_eu[0]);
    w_eh  = 10'($signed(w_ev) >>> 1);
    w_exp = 8'(w_eh + 10'd127);

    w_spec = 1'b1;
    w_sinv = 1'b0;
    w_sres = 32'd0;
    if (d[30:23] == 8'hFF) begin
      if (d[22:0] != 23'd0) begin
        w_sres = 32'h7FC0_0000;
        w_sinv = ~d[22];
      end else if (d[31]) begin
        w_sres = 32'h7FC0_0000;
        w_sinv = 1'b1;
      end else begin
        w_sres = 32'h7F80_0000;
      end
    end else if (d[30:0] == 31'd0) begin
      w_sres = d;
    end else if (d[31]) begin
      w_sres = 32'h7FC0_0000;
      w_sinv = 1'b1;
    end else begin
      w_spec = 1'b0;
    end
  end

  logic [16:0] w_lut [2**LUT_BITS];
  for (genvar gi = 0; gi < 2**LUT_BITS; gi++) begin : g_lut
    assign w_lut[gi] = rsqrt_seed(gi);
  end

  logic [LUT_BITS-1:0] w_lut_idx;
  assign w_lut_idx = LUT_BITS'(r_m >> (25 - LUT_BITS));

  // One multiplier shared by the three iteration phases and the final a*x.
  logic [35:0] w_mul_a, w_mul_b, w_three;
  logic [71:0] w_prod;
  assign w_three = 36'h3_0000_0000 - r_t;

  always_comb begin
    w_mul_a = 36'd0;
    w_mul_b = 36'd0;
    if (r_state == ST_ITER) begin
      case (r_phase)
        2'd0:    begin w_mul_a = 36'(r_x); w_mul_b = 36'(r_x); end
        2'd1:    begin w_mul_a = 36'(r_m); w_mul_b = r_t;      end
        default: begin w_mul_a = 36'(r_x); w_mul_b = w_three;  end
      endcase
    end else if (r_state == ST_MUL) begin
      w_mul_a = 36'(r_m);
      w_mul_b = 36'(r_x);
    end
  end
  assign w_prod = 72'(w_mul_a) * 72'(w_mul_b);

  // Exact correction: R = floor(sqrt(M * 2^25)) carries 24 result bits plus a guard bit;
  // the candidate from a*x is within one unit, so one signed remainder settles it.
  logic [24:0]        w_c, w_r;
  logic [49:0]        w_c2;
  logic signed [51:0] w_rem0, w_two_c1, w_rem;
  logic               w_up;
  logic [24:0]        w_sum;
  logic [22:0]        w_mant;
  logic [31:0]        w_res;
  logic               w_inx;

  always_comb begin
    w_c      = 25'(r_q >> 1);
    w_c2     = 50'(w_c) * 50'(w_c);
    w_rem0   = $signed({2'b00, r_m, 25'd0}) - $signed({2'b00, w_c2});
    w_two_c1 = $signed({26'd0, w_c, 1'b1});
    if (w_rem0 < 0) begin
      w_r   = w_c - 25'd1;
      w_rem = w_rem0 + w_two_c1 - 52'sd2;
    end else if (w_rem0 >= w_two_c1) begin
      w_r   = w_c + 25'd1;
      w_rem = w_rem0 - w_two_c1;
    end else begin
      w_r   = w_c;
      w_rem = w_rem0;
    end
    w_inx = w_r[0] | (|w_rem);
    case (r_rm)
      2'b00:   w_up = w_r[0] & ((|w_rem) | w_r[1]);
      2'b10:   w_up = w_inx;
      default: w_up = 1'b0;
    endcase
    w_sum  = {1'b0, w_r[24:1]} + {24'd0, w_up};
    w_mant = 23'(w_sum) & {23{~w_sum[24]}};
    w_res  = {1'b0, r_exp + {7'd0, w_sum[24]}, w_mant};
    if (r_spec) begin
      w_res = r_sres;
      w_inx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_phase <= 2'd0;
      r_rm    <= 2'd0;
      r_m     <= 25'd0;
      r_exp   <= 8'd0;
      r_spec  <= 1'b0;
      r_sinv  <= 1'b0;
      r_sres  <= 32'd0;
      r_x     <= 34'd0;
      r_t     <= 36'd0;
      r_q     <= 26'd0;
      r_s     <= 32'd0;
      r_inv   <= 1'b0;
      r_inx   <= 1'b0;
    end else if (busy && cancel) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_phase <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          if (start && !cancel) begin
            r_m     <= w_m25;
            r_exp   <= w_exp;
            r_rm    <= rm;
            r_spec  <= w_spec;
            r_sres  <= w_sres;
            r_sinv  <= w_sinv;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (r_spec) begin
            r_state <= ST_ROUND;
          end else begin
            r_x     <= {1'b0, w_lut[w_lut_idx], 16'd0};
            r_phase <= 2'd0;
            r_cnt   <= 3'd1;
            r_state <= ST_ITER;
          end
        end
        ST_ITER: begin
          case (r_phase)
            2'd0: begin
              r_t     <= 36'(w_prod >> 32);
              r_phase <= 2'd1;
            end
            2'd1: begin
              r_t     <= 36'(w_prod >> 23);
              r_phase <= 2'd2;
            end
            default: begin
              // x*(3 - a*x^2)/2: 64 fractional product bits, one extra shift halves
              r_x     <= 34'(w_prod >> 33);
              r_phase <= 2'd0;
              if (r_cnt == 3'(ITER)) begin
                r_cnt   <= 3'd0;
                r_state <= ST_MUL;
              end else begin
                r_cnt <= r_cnt + 3'd1;
              end
            end
          endcase
        end
        ST_MUL: begin
          r_q     <= 26'(w_prod >> 30);
          r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          r_s     <= w_res;
          r_inv   <= r_spec & r_sinv;
          r_inx   <= w_inx;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s       = r_s;
  assign invalid = r_inv;
  assign inexact = r_inx;
  assign count   = r_cnt;
  assign done    = (r_state == ST_DONE);
  assign busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule

// File: tb/tb_fsqrt_newton_iter.sv
module tb_fsqrt_newton_iter;
  localparam int ITER  = 3;
  localparam int LAT_N = 3 * ITER + 3;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] d = 32'd0;
  logic [1:0]  rm = 2'd0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] s;
  logic        done, busy, invalid, inexact;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_s = 32'd0;

  fsqrt_newton_iter #(.ITER(ITER), .LUT_BITS(8)) dut (
    .clk(clk), .clrn(clrn), .d(d), .rm(rm), .start(start), .cancel(cancel),
    .s(s), .done(done), .busy(busy), .invalid(invalid), .inexact(inexact), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer square root of the scaled significand, then IEEE rounding.
  function automatic void model(input logic [31:0] x, input logic [1:0] m,
                                output logic [31:0] res, output logic inv,
                                output logic inx, output int lat);
    logic [7:0]  e;
    logic [22:0] f;
    longint      n, r;
    int          ei, be;
    logic [23:0] q;
    logic        g, st, up;
    e = x[30:23];
    f = x[22:0];
    inv = 1'b0;
    inx = 1'b0;
    lat = 2;
    res = 32'd0;
    if (e == 8'hFF && f != 0) begin
      res = 32'h7FC00000;
      inv = ~f[22];
    end else if (e == 0 && f == 0) begin
      res = x;
    end else if (x[31]) begin
      res = 32'h7FC00000;
      inv = 1'b1;
    end else if (e == 8'hFF) begin
      res = 32'h7F800000;
    end else begin
      lat = LAT_N;
      if (e == 0) begin n = longint'(f); ei = -149; end
      else begin n = longint'({1'b1, f}); ei = int'(e) - 150; end
      if (ei % 2 != 0) begin n = n * 2; ei = ei - 1; end
      while (n < (longint'(1) << 50)) begin n = n * 4; ei = ei - 2; end
      r = longint'($sqrt(real'(n)));
      while (r * r > n) r = r - 1;
      while ((r + 1) * (r + 1) <= n) r = r + 1;
      q  = 24'(r >> 2);
      g  = r[1];
      st = r[0] | (r * r != n);
      be = ei / 2 + 152;
      inx = g | st;
      up = (m == 2'b00) ? (g & (st | q[0])) : (m == 2'b10) ? (g | st) : 1'b0;
      if (up) begin
        if (q == 24'hFFFFFF) begin q = 24'h800000; be = be + 1; end
        else q = q + 24'd1;
      end
      res = {1'b0, 8'(be), q[22:0]};
    end
  endfunction

  task automatic run_op(input logic [31:0] din, input logic [1:0] rmin, output int lat);
    @(negedge clk);
    d = din;
    rm = rmin;
    start = 1'b1;
    edge1();
    start = 1'b0;
    d = $urandom;
    rm = 2'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      edge1();
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] din, input logic [1:0] rmin);
    logic [31:0] er;
    logic        ei, ex;
    int          el, lat;
    model(din, rmin, er, ei, ex, el);
    run_op(din, rmin, lat);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_s"}, s, er);
    chk({tag, "_inv"}, invalid, ei);
    chk({tag, "_inx"}, inexact, ex);
    last_s = er;
  endtask

  initial begin
    logic [31:0] sp [8];
    logic [31:0] er, x;
    logic        ei, ex;
    int          el, nd, k, nn, p;
    sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
           32'h7FC00000, 32'h7F800001, 32'hFFC00000, 32'h80000001};

    #12;
    chk("rst_s", s, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inv", invalid, 0);
    chk("rst_inx", inexact, 0);
    chk("rst_count", count, 0);

    // first start on the first edge after release, with per-edge busy/count checks
    @(negedge clk);
    clrn = 1'b1;
    d = 32'h40800000;
    rm = 2'b00;
    start = 1'b1;
    edge1();
    start = 1'b0;
    for (int i = 1; i <= LAT_N; i++) begin
      edge1();
      if (i < LAT_N) begin
        chk("busy_in_flight", busy, 1);
        chk("done_early", done, 0);
      end
      if (i == 1) chk("count_it1", count, 1);
      if (i == 5) chk("count_it2", count, 2);
      if (i == 9) chk("count_it3", count, 3);
      if (i == 10) chk("count_mul", count, 0);
    end
    chk("sqrt4_done", done, 1);
    chk("sqrt4_busy", busy, 0);
    chk("sqrt4_s", s, 32'h40000000);
    chk("sqrt4_inx", inexact, 0);

    check_op("sqrt2_rne", 32'h40000000, 2'b00);
    chk("sqrt2_rne_val", s, 32'h3FB504F3);
    check_op("sqrt2_rdn", 32'h40000000, 2'b01);
    check_op("sqrt2_rup", 32'h40000000, 2'b10);
    chk("sqrt2_rup_val", s, 32'h3FB504F4);
    check_op("sqrt2_rtz", 32'h40000000, 2'b11);
    check_op("denorm_min", 32'h00000001, 2'b00);
    chk("denorm_min_val", s, 32'h1A3504F3);
    check_op("one", 32'h3F800000, 2'b00);
    check_op("neg4", 32'hC0800000, 2'b00);
    check_op("negzero", 32'h80000000, 2'b00);
    check_op("pinf", 32'h7F800000, 2'b00);
    check_op("qnan", 32'h7FC00000, 2'b00);

    // cancel four edges into an operation
    @(negedge clk);
    d = 32'h40800000;
    start = 1'b1;
    edge1();
    start = 1'b0;
    for (int i = 1; i < 4; i++) edge1();
    @(negedge clk);
    cancel = 1'b1;
    edge1();
    cancel = 1'b0;
    chk("cancel_busy", busy, 0);
    chk("cancel_count", count, 0);
    chk("cancel_s_held", s, last_s);
    nd = 0;
    for (int i = 0; i < 16; i++) begin
      edge1();
      if (done) nd++;
    end
    chk("cancel_no_done", nd, 0);
    check_op("after_cancel", 32'h41100000, 2'b00);
    chk("after_cancel_val", s, 32'h40400000);

    // start held high while busy: one done only
    model(32'h40400000, 2'b00, er, ei, ex, el);
    @(negedge clk);
    d = 32'h40400000;
    rm = 2'b00;
    start = 1'b1;
    edge1();
    d = 32'h3F800000;
    nd = 0;
    for (int i = 1; i < LAT_N; i++) begin
      edge1();
      if (done) nd++;
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      edge1();
      if (done) nd++;
    end
    chk("held_start_dones", nd, 1);
    chk("held_start_s", s, er);

    // reset asserted at edge 6 of an operation
    @(negedge clk);
    d = 32'h40000000;
    start = 1'b1;
    edge1();
    start = 1'b0;
    for (int i = 1; i <= 6; i++) edge1();
    clrn = 1'b0;
    #1;
    chk("midrst_s", s, 0);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", count, 0);
    chk("midrst_inx", inexact, 0);
    @(negedge clk);
    clrn = 1'b1;
    nd = 0;
    for (int i = 0; i < 16; i++) begin
      edge1();
      if (done) nd++;
    end
    chk("midrst_no_done", nd, 0);
    check_op("after_rst", 32'h40000000, 2'b00);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: x = $urandom;
        1: x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        2: x = {9'd0, 23'($urandom)};
        3: x = sp[$urandom_range(0, 7)];
        default: begin
          nn = $urandom_range(1, 4095);
          nn = nn * nn;
          p = 0;
          for (int b = 0; b < 24; b++) if (nn[b]) p = b;
          x = {1'b0, 8'(87 + p + 2 * $urandom_range(0, 40)), 23'(nn << (23 - p))};
        end
      endcase
      check_op("rand", x, 2'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
